// File: rtl/avalon_mem_responder.sv
// Avalon-MM target memory model with a waitrequest handshake, programmable
// and pseudo-random wait states, out-of-range trapping and access counters.
module avalon_mem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE      = 32'h0000_0000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_address,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  input  logic [3:0]  wait_cfg,
  input  logic        stall_en,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [31:0] err_count
);

  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] SPAN      = 33'(DEPTH) << 2;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;  // x^16+x^14+x^13+x^11+1
  localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t          state;
  state_t          state_next;

  logic            req;
  logic            hit;
  logic [31:0]     offset;
  logic [AW-1:0]   req_index;
  logic [15:0]     lfsr_next;

  logic            op_write;
  logic            op_err;
  logic [AW-1:0]   index;
  logic [5:0]      cnt;
  logic [15:0]     lfsr;
  logic [31:0]     rdata;
  logic [31:0]     mem [DEPTH];

  // Request decode: a simultaneous read and write is handled as a write.
  assign req       = avs_read | avs_write;
  assign offset    = avs_address - BASE;
  assign hit       = (avs_address >= BASE) && ({1'b0, offset} < SPAN) &&
                     (avs_address[1:0] == 2'b00);
  assign req_index = offset[AW+1:2];

  // Galois LFSR, shifting towards bit 0; the bit shifted out folds back into the taps.
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & LFSR_TAPS);

  // Handshake outputs are decoded from the state register only.
  assign avs_waitrequest = (state != S_ACK);
  assign avs_readdata    = (state == S_ACK) ? rdata : 32'h0;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values, matching real hardware regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic: accept, count down wait states, then acknowledge once.
  // NOTE: the default assignment up front keeps every path driven, so no
  // latch is inferred when a branch leaves the state unchanged.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (req) state_next = S_WAIT;
      S_WAIT:  if (cnt == 6'd0) state_next = S_ACK;
      S_ACK:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Access context capture, wait-state counter, stall LFSR and read register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_write <= 1'b0;
      op_err   <= 1'b0;
      index    <= '0;
      cnt      <= 6'd0;
      lfsr     <= LFSR_SEED;
      rdata    <= 32'h0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req) begin
            op_write <= avs_write;
            op_err   <= !hit;
            index    <= req_index;
            cnt      <= 6'(wait_cfg) + (stall_en ? 6'(lfsr[1:0]) : 6'd0);
            lfsr     <= lfsr_next;
          end
        end
        S_WAIT: begin
          if (cnt == 6'd0) begin
            if (!op_write) rdata <= op_err ? ERR_DATA : mem[index];
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage write on the edge that ends the acknowledge cycle.
  // NOTE: the array has no reset so it maps onto RAM; a reset during an
  // access cannot commit because the state register clears asynchronously.
  always_ff @(posedge clk) begin
    if (state == S_ACK && op_write && !op_err) mem[index] <= avs_writedata;
  end

  // Completion counters: exactly one advances per acknowledged access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_count  <= 32'h0;
      wr_count  <= 32'h0;
      err_count <= 32'h0;
    end else if (state == S_ACK) begin
      if (op_err)        err_count <= err_count + 32'd1;
      else if (op_write) wr_count  <= wr_count + 32'd1;
      else               rd_count  <= rd_count + 32'd1;
    end
  end

endmodule
